de0_vga: RTL and testbench



---
 rtl/de0_vga.sv | 168 ++++++++++++++++
 tb/tb_de0_vga.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/de0_vga.sv
// 1280x1024 raster timing generator and registered 4:4:4 RGB output stage for the DE0 GameBoy-to-VGA bridge.
// Optional build macro: DE0_VGA_TEST_PATTERN_EN replaces pixel_color with eight internal colour bars.
module de0_vga #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 48,
  parameter int H_SYNC   = 112,
  parameter int H_BP     = 248,
  parameter int V_ACTIVE = 1024,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 38,
  parameter bit SYNC_POL = 1'b1,
  parameter int PIPE_DLY = 2
) (
  input  logic        clk_50,
  input  logic        rst_n,
  input  logic [11:0] pixel_color,
  output logic [3:0]  VGA_BUS_R,
  output logic [3:0]  VGA_BUS_G,
  output logic [3:0]  VGA_BUS_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic [10:0] X_pix,
  output logic [10:0] Y_pix,
  output logic        H_visible,
  output logic        V_visible,
  output logic        pixel_clk,
  output logic [9:0]  pixel_cnt
);

  // Totals must fit the 11-bit counters (<= 2047); PIPE_DLY must be at least 2.
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT        = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT        = 11'(V_ACTIVE);
  localparam logic [10:0] H_SYNC_FIRST = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] V_SYNC_FIRST = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [10:0] r_x;
  logic [10:0] r_y;
  logic [9:0]  r_frame;

  logic        w_x_wrap;
  logic        w_y_wrap;
  logic        w_hs_raw;
  logic        w_vs_raw;
  logic        w_blank;

  // Sync pipes span the full delay; the blank pipe is one shorter because the
  // colour register itself supplies the final stage.
  logic [PIPE_DLY-1:0] r_hs_pipe;
  logic [PIPE_DLY-1:0] r_vs_pipe;
  logic [PIPE_DLY-2:0] r_blank_pipe;

  logic [11:0] w_color_src;
  logic [11:0] r_rgb;

  assign w_x_wrap = (r_x == H_LAST);
  assign w_y_wrap = (r_y == V_LAST);

  assign H_visible = (r_x < H_ACT);
  assign V_visible = (r_y < V_ACT);
  assign w_blank   = !(H_visible && V_visible);

  assign w_hs_raw = ((r_x >= H_SYNC_FIRST) && (r_x <= H_SYNC_LAST)) ? SYNC_POL : !SYNC_POL;
  assign w_vs_raw = ((r_y >= V_SYNC_FIRST) && (r_y <= V_SYNC_LAST)) ? SYNC_POL : !SYNC_POL;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_x     <= '0;
      r_y     <= '0;
      r_frame <= '0;
    end else if (w_x_wrap) begin
      r_x <= '0;
      if (w_y_wrap) begin
        r_y     <= '0;
        r_frame <= r_frame + 10'd1;
      end else begin
        r_y <= r_y + 11'd1;
      end
    end else begin
      r_x <= r_x + 11'd1;
    end
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_hs_pipe    <= {PIPE_DLY{!SYNC_POL}};
      r_vs_pipe    <= {PIPE_DLY{!SYNC_POL}};
      r_blank_pipe <= '1;
    end else begin
      r_hs_pipe[0]    <= w_hs_raw;
      r_vs_pipe[0]    <= w_vs_raw;
      r_blank_pipe[0] <= w_blank;
      for (int i = 1; i < PIPE_DLY; i++) begin
        r_hs_pipe[i] <= r_hs_pipe[i-1];
        r_vs_pipe[i] <= r_vs_pipe[i-1];
      end
      for (int i = 1; i < PIPE_DLY - 1; i++) begin
        r_blank_pipe[i] <= r_blank_pipe[i-1];
      end
    end
  end

`ifdef DE0_VGA_TEST_PATTERN_EN
  localparam logic [10:0] BAR_W = 11'(H_ACTIVE / 8);

  logic [10:0] r_x_pipe [PIPE_DLY-1];
  logic [10:0] w_bar_idx;

  // NOTE: this short pipe is reset explicitly; it is a handful of flops, not
  // a RAM, so the reset costs nothing and keeps post-reset colour defined.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_DLY - 1; i++) r_x_pipe[i] <= '0;
    end else begin
      r_x_pipe[0] <= r_x;
      for (int i = 1; i < PIPE_DLY - 1; i++) r_x_pipe[i] <= r_x_pipe[i-1];
    end
  end

  assign w_bar_idx = r_x_pipe[PIPE_DLY-2] / BAR_W;

  // NOTE: the default before the case keeps this purely combinational (no latch).
  always_comb begin
    w_color_src = 12'h000;
    case (w_bar_idx)
      11'd0:   w_color_src = 12'hFFF;
      11'd1:   w_color_src = 12'hFF0;
      11'd2:   w_color_src = 12'h0FF;
      11'd3:   w_color_src = 12'h0F0;
      11'd4:   w_color_src = 12'hF0F;
      11'd5:   w_color_src = 12'hF00;
      11'd6:   w_color_src = 12'h00F;
      default: w_color_src = 12'h000;
    endcase
  end
`else
  assign w_color_src = pixel_color;
`endif

  // Colour is gated by the blank of the same raster position it belongs to.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb <= '0;
    end else begin
      r_rgb <= r_blank_pipe[PIPE_DLY-2] ? 12'h000 : w_color_src;
    end
  end

  assign VGA_BUS_R = r_rgb[11:8];
  assign VGA_BUS_G = r_rgb[7:4];
  assign VGA_BUS_B = r_rgb[3:0];
  assign VGA_HS    = r_hs_pipe[PIPE_DLY-1];
  assign VGA_VS    = r_vs_pipe[PIPE_DLY-1];
  assign X_pix     = r_x;
  assign Y_pix     = r_y;
  assign pixel_cnt = r_frame;
  assign pixel_clk = clk_50;

endmodule

// File: tb/tb_de0_vga.sv
// Self-checking bench for de0_vga on a reduced raster so full frames and the frame-counter wrap fit a short run.
// The model derives every output from the cycle count since reset using plain division/modulo.
module tb_de0_vga;

  localparam int H_ACTIVE = 8;
  localparam int H_FP     = 1;
  localparam int H_SYNC   = 2;
  localparam int H_BP     = 1;
  localparam int V_ACTIVE = 1;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 1;
  localparam bit SYNC_POL = 1'b1;
  localparam int PIPE_DLY = 2;
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic        clk_50 = 1'b0;
  logic        rst_n  = 1'b1;
  logic [11:0] pixel_color = 12'hA5C;
  logic [3:0]  VGA_BUS_R, VGA_BUS_G, VGA_BUS_B;
  logic        VGA_HS, VGA_VS;
  logic [10:0] X_pix, Y_pix;
  logic        H_visible, V_visible;
  logic        pixel_clk;
  logic [9:0]  pixel_cnt;

  int          errors = 0;
  int          checks = 0;
  int          t = 0;
  bit          rand_mode = 1'b0;
  logic [11:0] col_hist [4];

  typedef struct {
    logic [10:0] x;
    logic [10:0] y;
    logic [9:0]  cnt;
    logic        hv;
    logic        vv;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } exp_t;

  de0_vga #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(SYNC_POL), .PIPE_DLY(PIPE_DLY)
  ) dut (
    .clk_50(clk_50), .rst_n(rst_n), .pixel_color(pixel_color),
    .VGA_BUS_R(VGA_BUS_R), .VGA_BUS_G(VGA_BUS_G), .VGA_BUS_B(VGA_BUS_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .X_pix(X_pix), .Y_pix(Y_pix),
    .H_visible(H_visible), .V_visible(V_visible), .pixel_clk(pixel_clk),
    .pixel_cnt(pixel_cnt)
  );

  always #5 clk_50 = ~clk_50;

  // Rising edges since the last reset release.
  always @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) t <= 0;
    else        t <= t + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0d: got %0h, expected %0h", name, t, act, exp);
    end
  endtask

  function automatic logic [11:0] bar_color(input int idx);
    case (idx)
      0: return 12'hFFF;
      1: return 12'hFF0;
      2: return 12'h0FF;
      3: return 12'h0F0;
      4: return 12'hF0F;
      5: return 12'hF00;
      6: return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  function automatic exp_t model(input int tt);
    exp_t e;
    int x, y, td, xd, yd;
    logic [11:0] src;
    x     = tt % HT;
    y     = (tt / HT) % VT;
    e.x   = 11'(x);
    e.y   = 11'(y);
    e.cnt = 10'((tt / (HT * VT)) % 1024);
    e.hv  = (x < H_ACTIVE);
    e.vv  = (y < V_ACTIVE);
    e.hs  = !SYNC_POL;
    e.vs  = !SYNC_POL;
    e.rgb = 12'h000;
    if (tt >= PIPE_DLY) begin
      td = tt - PIPE_DLY;
      xd = td % HT;
      yd = (td / HT) % VT;
      if (xd >= H_ACTIVE + H_FP && xd < H_ACTIVE + H_FP + H_SYNC) e.hs = SYNC_POL;
      if (yd >= V_ACTIVE + V_FP && yd < V_ACTIVE + V_FP + V_SYNC) e.vs = SYNC_POL;
`ifdef DE0_VGA_TEST_PATTERN_EN
      src = bar_color(xd / (H_ACTIVE / 8));
`else
      src = col_hist[(tt - 1) % 4];
`endif
      if (xd < H_ACTIVE && yd < V_ACTIVE) e.rgb = src;
    end
    return e;
  endfunction

  // Colour driver: new value just after each falling edge, logged by cycle.
  initial begin
    for (int i = 0; i < 4; i++) col_hist[i] = 12'hA5C;
    forever begin
      @(negedge clk_50);
      #1;
      pixel_color = rand_mode ? 12'($urandom) : 12'hA5C;
      col_hist[t % 4] = pixel_color;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk_50) begin : cmp
    exp_t e;
    e = model(t);
    check("x_pix",     X_pix,     e.x);
    check("y_pix",     Y_pix,     e.y);
    check("pixel_cnt", pixel_cnt, e.cnt);
    check("h_visible", H_visible, e.hv);
    check("v_visible", V_visible, e.vv);
    check("vga_hs",    VGA_HS,    e.hs);
    check("vga_vs",    VGA_VS,    e.vs);
    check("vga_rgb",   {VGA_BUS_R, VGA_BUS_G, VGA_BUS_B}, e.rgb);
    check("pixel_clk", pixel_clk, clk_50);
  end

  task automatic wait_t(input int target);
    int guard;
    guard = 0;
    while (t != target) begin
      @(negedge clk_50);
      guard++;
      if (guard > 70000) begin
        checks++;
        errors++;
        $display("FAIL wait_t: t=%0d never reached %0d", t, target);
        return;
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_x"},    X_pix, 0);
    check({tag, "_y"},    Y_pix, 0);
    check({tag, "_cnt"},  pixel_cnt, 0);
    check({tag, "_rgb"},  {VGA_BUS_R, VGA_BUS_G, VGA_BUS_B}, 0);
    check({tag, "_hs"},   VGA_HS, 0);
    check({tag, "_vs"},   VGA_VS, 0);
    check({tag, "_hvis"}, H_visible, 1);
    check({tag, "_vvis"}, V_visible, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    @(posedge clk_50);
    #1 check("pixel_clk_high", pixel_clk, 1);
    check_reset_values("rst");
    repeat (2) @(posedge clk_50);
    #2 rst_n = 1'b1;

    wait_t(1);  check("first_edge_x", X_pix, 1);
`ifdef DE0_VGA_TEST_PATTERN_EN
    wait_t(2);  check("bar_x0",   {VGA_BUS_R, VGA_BUS_G, VGA_BUS_B}, 12'hFFF);
    wait_t(6);  check("bar_xmid", {VGA_BUS_R, VGA_BUS_G, VGA_BUS_B}, 12'hF0F);
`endif
    wait_t(8);  check("hvis_off_x", X_pix, 8); check("hvis_off", H_visible, 0);
    wait_t(9);
`ifdef DE0_VGA_TEST_PATTERN_EN
    check("rgb_last_vis", {VGA_BUS_R, VGA_BUS_G, VGA_BUS_B}, 12'h000);
`else
    check("rgb_last_vis", {VGA_BUS_R, VGA_BUS_G, VGA_BUS_B}, 12'hA5C);
`endif
    wait_t(10); check("rgb_first_blank", {VGA_BUS_R, VGA_BUS_G, VGA_BUS_B}, 0);
                check("hs_before", VGA_HS, 0);
    wait_t(11); check("hs_first", VGA_HS, 1);
    wait_t(12); check("hs_second", VGA_HS, 1);
                check("line_wrap_x", X_pix, 0); check("line_wrap_y", Y_pix, 1);
    wait_t(13); check("hs_after", VGA_HS, 0);
    wait_t(25); check("vs_before", VGA_VS, 0);
    wait_t(26); check("vs_first", VGA_VS, 1);
    wait_t(49); check("vs_last", VGA_VS, 1);
    wait_t(50); check("vs_after", VGA_VS, 0);
    wait_t(60); check("frame1_cnt", pixel_cnt, 1);
                check("frame1_x", X_pix, 0); check("frame1_y", Y_pix, 0);

    rand_mode = 1'b1;
    wait_t(61380); check("cnt_1023", pixel_cnt, 1023);
    wait_t(61440); check("cnt_wrap", pixel_cnt, 0);
                   check("wrap_x", X_pix, 0); check("wrap_y", Y_pix, 0);

    wait_t(61486);
    @(posedge clk_50);
    #1 check("pre_rst_x", X_pix, 11); check("pre_rst_y", Y_pix, 3);
    #1 rst_n = 1'b0;
    #1 check_reset_values("midrst");
    repeat (3) @(posedge clk_50);
    #2 rst_n = 1'b1;
    wait_t(1);   check("restart_x", X_pix, 1); check("restart_y", Y_pix, 0);
    wait_t(150);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
